// File: rtl/playback_ctrl_if.sv
// Sample-memory read port and DAC serializer sample port of playback_ctrl.
interface playback_ctrl_if #(
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 16
);
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [SAMPLE_W-1:0] mem_rdata;
  logic                smp_valid;
  logic [SAMPLE_W-1:0] smp_data;
  logic                smp_ready;

  modport master (
    output mem_req, mem_addr, smp_valid, smp_data,
    input  mem_ack, mem_rdata, smp_ready
  );

  modport slave (
    input  mem_req, mem_addr, smp_valid, smp_data,
    output mem_ack, mem_rdata, smp_ready
  );
endinterface

// File: rtl/playback_ctrl.sv
// Button-driven playback sequencer: fetches PCM samples over a req/ack
// memory port and hands them to the DAC serializer over valid/ready.
module playback_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int TRACK_LEN  = 16384,
  parameter int ADDR_W     = 16,
  parameter int SAMPLE_W   = 16,
  parameter int DEB_CYC    = 500000
) (
  input  logic                          clk_fpga,
  input  logic                          rst,
  input  logic [3:0]                    buttons,
  playback_ctrl_if.master               bus,
  output logic                          playing,
  output logic                          paused,
  output logic [$clog2(NUM_TRACKS)-1:0] track,
  output logic [$clog2(TRACK_LEN)-1:0]  pos
);
  localparam int TW = $clog2(NUM_TRACKS);
  localparam int CW = $clog2(DEB_CYC);

  typedef enum logic [1:0] {ST_STOP, ST_FETCH, ST_PRESENT, ST_PAUSE} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_PLAY, CMD_STOP, CMD_NEXT, CMD_PREV} cmd_t;

  state_t              state;
  cmd_t                pend;
  cmd_t                new_cmd;
  logic                held;
  logic [SAMPLE_W-1:0] sample;

  logic [3:0]    sync1, sync2, deb, ev;
  logic [CW-1:0] cnt [4];

  // Per-key synchronizer and debouncer; a press (debounced 1->0) pulses ev.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      ev    <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      ev    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
          ev[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Same-cycle events resolve stop > prev > next > play.
  always_comb begin
    new_cmd = CMD_NONE;
    if (ev[1])      new_cmd = CMD_STOP;
    else if (ev[3]) new_cmd = CMD_PREV;
    else if (ev[2]) new_cmd = CMD_NEXT;
    else if (ev[0]) new_cmd = CMD_PLAY;
  end

  function automatic logic [TW-1:0] step_track(input logic [TW-1:0] t, input cmd_t c);
    return (c == CMD_PREV) ? t - TW'(1) : t + TW'(1);
  endfunction

  // Playback FSM with track/position, sample register and pending command.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      state  <= ST_STOP;
      pend   <= CMD_NONE;
      held   <= 1'b0;
      sample <= '0;
      track  <= '0;
      pos    <= '0;
    end else begin
      case (state)
        ST_STOP: begin
          pend <= CMD_NONE;
          case (pend)
            CMD_PLAY: state <= ST_FETCH;
            CMD_NEXT, CMD_PREV: begin
              track <= step_track(track, pend);
              pos   <= '0;
            end
            default: ;
          endcase
        end
        ST_FETCH: begin
          if (bus.mem_ack) begin
            sample <= bus.mem_rdata;
            held   <= 1'b1;
            state  <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (bus.smp_ready) begin
            held <= 1'b0;
            pend <= CMD_NONE;
            case (pend)
              CMD_STOP: begin
                state <= ST_STOP;
                pos   <= '0;
              end
              CMD_PLAY: begin
                state <= ST_PAUSE;
                pos   <= pos + 1'b1;
              end
              CMD_NEXT, CMD_PREV: begin
                track <= step_track(track, pend);
                pos   <= '0;
                state <= ST_FETCH;
              end
              default: begin
                // pos wraps naturally; end of track advances to the next one.
                pos   <= pos + 1'b1;
                if (&pos) track <= track + TW'(1);
                state <= ST_FETCH;
              end
            endcase
          end
        end
        ST_PAUSE: begin
          pend <= CMD_NONE;
          case (pend)
            CMD_PLAY: state <= held ? ST_PRESENT : ST_FETCH;
            CMD_STOP: begin
              state <= ST_STOP;
              pos   <= '0;
              held  <= 1'b0;
            end
            CMD_NEXT, CMD_PREV: begin
              track <= step_track(track, pend);
              pos   <= '0;
              held  <= 1'b0;
            end
            default: ;
          endcase
        end
        default: state <= ST_STOP;
      endcase
      // A fresh event overrides both the held command and its consumption.
      if (new_cmd != CMD_NONE) pend <= new_cmd;
    end
  end

  // Handshake and status outputs decode directly from the state flop.
  assign bus.mem_req   = (state == ST_FETCH);
  assign bus.smp_valid = (state == ST_PRESENT);
  assign bus.smp_data  = sample;
  // Power-of-two sizes make track*TRACK_LEN + pos a plain concatenation.
  assign bus.mem_addr  = ADDR_W'({track, pos});
  assign playing       = (state == ST_FETCH) || (state == ST_PRESENT);
  assign paused        = (state == ST_PAUSE);
endmodule

// File: tb/tb_playback_ctrl.sv
// Directed self-checking bench for playback_ctrl (TRACK_LEN=8, DEB_CYC=4).
module tb_playback_ctrl;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttons = 4'hF;
  logic       playing, paused;
  logic [1:0] track;
  logic [2:0] pos;

  int tests = 0;
  int fails = 0;
  int stab_err = 0;
  logic mem_en = 1'b1;
  logic ready_en = 1'b1;
  logic [1:0] lat;
  logic [2:0] rc;
  logic [15:0] dq[$];
  logic [15:0] fq[$];
  logic pv_valid, pv_ready, pv_req, pv_ack;
  logic [15:0] pv_data, pv_addr;

  playback_ctrl_if #(.ADDR_W(16), .SAMPLE_W(16)) bus ();

  playback_ctrl #(
    .NUM_TRACKS(4), .TRACK_LEN(8), .ADDR_W(16), .SAMPLE_W(16), .DEB_CYC(DEB)
  ) dut (
    .clk_fpga(clk), .rst(rst), .buttons(buttons), .bus(bus.master),
    .playing(playing), .paused(paused), .track(track), .pos(pos)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA500 + a;
  endfunction

  // Memory: acknowledges two cycles after request, when enabled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= '0;
      lat           <= '0;
    end else begin
      bus.mem_ack <= 1'b0;
      if (bus.mem_req && !bus.mem_ack && mem_en) begin
        if (lat == 2'd1) begin
          bus.mem_ack   <= 1'b1;
          bus.mem_rdata <= mem_word(bus.mem_addr);
          lat           <= '0;
        end else begin
          lat <= lat + 2'd1;
        end
      end
    end
  end

  // Serializer: ready one cycle in eight.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rc            <= '0;
      bus.smp_ready <= 1'b0;
    end else begin
      rc            <= rc + 3'd1;
      bus.smp_ready <= ready_en && (rc == 3'd7);
    end
  end

  // Transfer log and handshake-stability monitor.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_req && bus.mem_ack) fq.push_back(bus.mem_addr);
      if (bus.smp_valid && bus.smp_ready) dq.push_back(bus.smp_data);
      if (pv_valid && !pv_ready && !(bus.smp_valid && bus.smp_data == pv_data)) stab_err++;
      if (pv_req && !pv_ack && !(bus.mem_req && bus.mem_addr == pv_addr)) stab_err++;
    end
    pv_valid <= bus.smp_valid;
    pv_ready <= bus.smp_ready;
    pv_data  <= bus.smp_data;
    pv_req   <= bus.mem_req;
    pv_ack   <= bus.mem_ack;
    pv_addr  <= bus.mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    buttons = 4'hF & ~mask;
    repeat (DEB + 4) @(negedge clk);
    buttons = 4'hF;
    repeat (DEB + 4) @(negedge clk);
  endtask

  int n, base, pos_p;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_valid", 32'(bus.smp_valid), 0);
    chk("rst_status", 32'({playing, paused, track, pos}), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_data", 32'(bus.smp_data), 0);
    rst = 1'b0;

    // Play from reset: sequential addresses, data matches memory.
    press(4'b0001);
    chk("play_playing", 32'(playing), 1);
    for (int i = 0; i < 300; i++) begin if (dq.size() >= 3) break; @(negedge clk); end
    chk("play_tmo", 32'(dq.size() >= 3), 1);
    chk("play_f0", 32'(fq[0]), 0);
    chk("play_f2", 32'(fq[2]), 2);
    chk("play_d0", 32'(dq[0]), 32'(mem_word(16'd0)));
    chk("play_d2", 32'(dq[2]), 32'(mem_word(16'd2)));

    // Pause while a memory request is outstanding.
    mem_en = 1'b0;
    for (int i = 0; i < 100; i++) begin if (bus.mem_req) break; @(negedge clk); end
    chk("stall_req", 32'(bus.mem_req), 1);
    pos_p = int'(pos);
    chk("stall_pos", 32'(pos_p), 32'(dq.size()));
    chk("stall_addr", 32'(bus.mem_addr), 32'(pos_p));
    press(4'b0001);
    chk("stall_req_held", 32'(bus.mem_req), 1);
    chk("stall_not_paused", 32'(paused), 0);
    n = dq.size();
    mem_en = 1'b1;
    for (int i = 0; i < 100; i++) begin if (paused) break; @(negedge clk); end
    chk("pause_paused", 32'(paused), 1);
    chk("pause_valid", 32'(bus.smp_valid), 0);
    chk("pause_pos", 32'(pos), 32'(pos_p + 1));
    chk("pause_count", 32'(dq.size()), 32'(n + 1));
    chk("pause_data", 32'(dq[n]), 32'(mem_word(16'(pos_p))));
    n = fq.size();
    press(4'b0001);
    for (int i = 0; i < 100; i++) begin if (fq.size() > n) break; @(negedge clk); end
    chk("resume_addr", (fq.size() > n) ? 32'(fq[n]) : 32'hFFFF_FFFF, 32'(pos_p + 1));

    // Stop, then prev from track 0 wraps to track 3.
    press(4'b0010);
    for (int i = 0; i < 200; i++) begin if (!playing) break; @(negedge clk); end
    chk("stop_state", 32'({playing, paused}), 0);
    chk("stop_pos", 32'({track, pos}), 0);
    press(4'b1000);
    chk("prev_wrap", 32'({track, pos}), 32'({2'd3, 3'd0}));
    chk("prev_addr", 32'(bus.mem_addr), 24);

    // End of track 3 rolls over to track 0 and keeps playing.
    base = dq.size();
    press(4'b0001);
    for (int i = 0; i < 400; i++) begin if (dq.size() >= base + 6) break; @(negedge clk); end
    chk("eot_pre", 32'({track, pos}), 32'({2'd3, 3'd6}));
    for (int i = 0; i < 200; i++) begin if (dq.size() >= base + 8) break; @(negedge clk); end
    chk("eot_wrap", 32'({track, pos}), 0);
    chk("eot_playing", 32'(playing), 1);
    chk("eot_addr", 32'(bus.mem_addr), 0);
    chk("eot_last_addr", 32'(fq[base + 7]), 31);
    chk("eot_last_data", 32'(dq[base + 7]), 32'(mem_word(16'd31)));

    // Next to track 1, then simultaneous next+stop: stop wins.
    press(4'b0100);
    for (int i = 0; i < 100; i++) begin if (track == 2'd1) break; @(negedge clk); end
    chk("next_trk", 32'({track, pos}), 32'({2'd1, 3'd0}));
    n = dq.size();
    for (int i = 0; i < 100; i++) begin if (dq.size() >= n + 2) break; @(negedge clk); end
    press(4'b0110);
    for (int i = 0; i < 200; i++) begin if (!playing) break; @(negedge clk); end
    chk("stopwins_state", 32'({playing, paused, bus.mem_req, bus.smp_valid}), 0);
    chk("stopwins_trk", 32'({track, pos}), 32'({2'd1, 3'd0}));

    // Pause on track 0, prev wraps to 3, play fetches 3*TRACK_LEN.
    press(4'b1000);
    chk("prev_stop", 32'(track), 0);
    press(4'b0001);
    press(4'b0001);
    for (int i = 0; i < 200; i++) begin if (paused) break; @(negedge clk); end
    chk("p2_paused", 32'({paused, playing, bus.smp_valid}), 32'(3'b100));
    press(4'b1000);
    chk("p2_prev", 32'({paused, track, pos}), 32'({1'b1, 2'd3, 3'd0}));
    n = fq.size();
    press(4'b0001);
    for (int i = 0; i < 100; i++) begin if (fq.size() > n) break; @(negedge clk); end
    chk("p2_addr", (fq.size() > n) ? 32'(fq[n]) : 32'hFFFF_FFFF, 24);
    chk("p2_playing", 32'(playing), 1);

    // Stop-key glitch one cycle short of the debounce window.
    @(negedge clk);
    buttons = 4'b1101;
    repeat (DEB - 1) @(negedge clk);
    buttons = 4'hF;
    repeat (30) @(negedge clk);
    chk("glitch", 32'({playing, paused}), 32'(2'b10));

    chk("stability", 32'(stab_err), 0);

    // Asynchronous reset while a sample is presented.
    ready_en = 1'b0;
    for (int i = 0; i < 100; i++) begin if (bus.smp_valid) break; @(negedge clk); end
    chk("arst_pre", 32'(bus.smp_valid), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_handshake", 32'({bus.mem_req, bus.smp_valid}), 0);
    chk("arst_status", 32'({playing, paused, track, pos}), 0);
    chk("arst_data", 32'({bus.smp_data, bus.mem_addr}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
